// File: rtl/rect_overlay_draw_if.sv
// Video stream bundle for rect_overlay_draw: input timing/pixel, detector box, delayed output.
// master drives the input stream and box; slave is the overlay itself.
interface rect_overlay_draw_if #(
    parameter int DATA_W = 16
);
    logic              per_frame_vsync;
    logic              per_frame_href;
    logic              per_frame_clken;
    logic [DATA_W-1:0] per_img_data;
    logic              rect_flag;
    logic [9:0]        rect_up;
    logic [9:0]        rect_down;
    logic [9:0]        rect_left;
    logic [9:0]        rect_right;
    logic              post_frame_vsync;
    logic              post_frame_href;
    logic              post_frame_clken;
    logic [DATA_W-1:0] post_img_data;

    modport master (
        output per_frame_vsync, per_frame_href, per_frame_clken, per_img_data,
        output rect_flag, rect_up, rect_down, rect_left, rect_right,
        input  post_frame_vsync, post_frame_href, post_frame_clken, post_img_data
    );

    modport slave (
        input  per_frame_vsync, per_frame_href, per_frame_clken, per_img_data,
        input  rect_flag, rect_up, rect_down, rect_left, rect_right,
        output post_frame_vsync, post_frame_href, post_frame_clken, post_img_data
    );
endinterface

// File: rtl/rect_overlay_draw.sv
// Paints the outline of the detector's bounding box onto the pixel stream, 1-cycle latency.
// Box bounds are captured at frame start so the drawn box never tears mid-frame.
module rect_overlay_draw #(
    parameter int              DATA_W    = 16,
    parameter int              LINE_W    = 2,
    parameter logic [DATA_W-1:0] BOX_COLOR = 16'hF800
) (
    input logic               clk,
    input logic               rst,
    rect_overlay_draw_if.slave bus
);
    localparam logic [9:0]  CNT_MAX = '1;
    localparam logic [10:0] LW      = 11'(LINE_W);

    logic              href_q, vsync_q, armed_q;
    logic              lat_flag_q;
    logic [9:0]        lat_up_q, lat_down_q, lat_left_q, lat_right_q;
    logic [9:0]        x_q, x_d, y_q, y_d;
    logic              post_vsync_q, post_href_q, post_clken_q;
    logic [DATA_W-1:0] post_data_q, post_data_d;

    logic        pix_valid, href_fall, vsync_rise;
    logic [10:0] x_e, y_e, up_e, down_e, left_e, right_e;
    logic        lat_valid, in_cols, in_rows, on_edge, hit;

    assign pix_valid = bus.per_frame_href & bus.per_frame_clken;
    assign href_fall = href_q & ~bus.per_frame_href;
    // armed_q stops a vsync that was already high across a reset from posing as a new frame start.
    assign vsync_rise = armed_q & ~vsync_q & bus.per_frame_vsync;

    // A pixel coinciding with frame start sits on row 0; compare in 11 bits so edges never wrap.
    assign x_e     = {1'b0, x_q};
    assign y_e     = vsync_rise ? 11'd0 : {1'b0, y_q};
    assign up_e    = {1'b0, lat_up_q};
    assign down_e  = {1'b0, lat_down_q};
    assign left_e  = {1'b0, lat_left_q};
    assign right_e = {1'b0, lat_right_q};

    assign lat_valid = lat_flag_q & (lat_up_q <= lat_down_q) & (lat_left_q <= lat_right_q);
    assign in_cols   = (left_e <= x_e) & (x_e <= right_e);
    assign in_rows   = (up_e <= y_e) & (y_e <= down_e);
    assign on_edge   = (x_e < left_e + LW) | (x_e + LW > right_e) |
                       (y_e < up_e + LW)   | (y_e + LW > down_e);
    assign hit       = lat_valid & in_cols & in_rows & on_edge;

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path leaves a latch behind.
        x_d         = x_q;
        y_d         = y_q;
        post_data_d = bus.per_img_data;
        if (href_fall) begin
            x_d = '0;
        end else if (pix_valid && x_q != CNT_MAX) begin
            x_d = x_q + 10'd1;
        end
        if (vsync_rise) begin
            y_d = '0;
        end else if (href_fall && y_q != CNT_MAX) begin
            y_d = y_q + 10'd1;
        end
        if (pix_valid && hit) begin
            post_data_d = BOX_COLOR;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            href_q       <= 1'b0;
            vsync_q      <= 1'b0;
            armed_q      <= 1'b0;
            lat_flag_q   <= 1'b0;
            lat_up_q     <= '0;
            lat_down_q   <= '0;
            lat_left_q   <= '0;
            lat_right_q  <= '0;
            x_q          <= '0;
            y_q          <= '0;
            post_vsync_q <= 1'b0;
            post_href_q  <= 1'b0;
            post_clken_q <= 1'b0;
            post_data_q  <= '0;
        end else begin
            href_q  <= bus.per_frame_href;
            vsync_q <= bus.per_frame_vsync;
            if (!bus.per_frame_vsync) begin
                armed_q <= 1'b1;
            end
            if (vsync_rise) begin
                lat_flag_q  <= bus.rect_flag;
                lat_up_q    <= bus.rect_up;
                lat_down_q  <= bus.rect_down;
                lat_left_q  <= bus.rect_left;
                lat_right_q <= bus.rect_right;
            end
            x_q          <= x_d;
            y_q          <= y_d;
            post_vsync_q <= bus.per_frame_vsync;
            post_href_q  <= bus.per_frame_href;
            post_clken_q <= bus.per_frame_clken;
            post_data_q  <= post_data_d;
        end
    end

    assign bus.post_frame_vsync = post_vsync_q;
    assign bus.post_frame_href  = post_href_q;
    assign bus.post_frame_clken = post_clken_q;
    assign bus.post_img_data    = post_data_q;
endmodule
